// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one 8N1 UART byte
// transmitter between N_REQ byte-stream requesters.
//   - A grant is held for a whole packet, so bytes from different owners never interleave.
//   - A byte is issued only while the transmitter reports IDLE.
//   - Each byte is acknowledged to its owner with a one-cycle ACK.
// Optional feature: define UART_ARB_BURST_LIMIT_EN to release the grant after
// MAX_BURST bytes even if the packet is not finished.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   REQ[N_REQ]         per-requester request, held while a byte is presented
//   REQ_DATA[8*N_REQ]  byte of requester i on bits [8i+7:8i]
//   REQ_LAST[N_REQ]    presented byte closes its packet
//   GRANT[N_REQ]       one-hot owner of the transmitter, 0 when free
//   ACK[N_REQ]         one-cycle pulse, presented byte taken
//   TX_DATA[8]         byte to transmitter DATA
//   TX_DATA_READY      one-cycle send strobe to transmitter DATA_READY
//   TX_IDLE            transmitter IDLE
//   BUSY               arbiter not in S_IDLE
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]   REQ_LAST,
    output logic [N_REQ-1:0]   GRANT,
    output logic [N_REQ-1:0]   ACK,
    output logic [7:0]         TX_DATA,
    output logic               TX_DATA_READY,
    input  logic               TX_IDLE,
    output logic               BUSY
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("uart_tx_arbiter: MAX_BURST must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;     // index of current owner
    logic [IDX_W-1:0]   ptr_q, ptr_d;       // round-robin search start
    logic               last_q, last_d;     // byte in flight closes the packet
    logic               burst_hit_c;

    logic               arb_hit;
    logic [IDX_W-1:0]   arb_pick;
    logic [IDX_W-1:0]   arb_cand;

    logic [N_REQ-1:0]   grant_d;
    logic [N_REQ-1:0]   ack_d;
    logic               strobe_d;
    logic [7:0]         tx_data_d;
    logic               busy_d;

`ifdef UART_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0]   burst_q, burst_d;

    assign burst_hit_c = (burst_q >= CNT_W'(MAX_BURST));
`else
    assign burst_hit_c = 1'b0;
`endif

    // Next index modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (32'(i) == N_REQ - 1) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // First requesting index at or above ptr, wrapping.
    always_comb begin
        arb_hit  = 1'b0;
        arb_pick = '0;
        arb_cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            arb_cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
            if (!arb_hit && REQ[arb_cand]) begin
                arb_hit  = 1'b1;
                arb_pick = arb_cand;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            gidx_q        <= '0;
            ptr_q         <= '0;
            last_q        <= 1'b0;
            GRANT         <= '0;
            ACK           <= '0;
            TX_DATA_READY <= 1'b0;
            TX_DATA       <= 8'h00;
            BUSY          <= 1'b0;
`ifdef UART_ARB_BURST_LIMIT_EN
            burst_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            GRANT         <= grant_d;
            ACK           <= ack_d;
            TX_DATA_READY <= strobe_d;
            TX_DATA       <= tx_data_d;
            BUSY          <= busy_d;
`ifdef UART_ARB_BURST_LIMIT_EN
            burst_q       <= burst_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
`ifdef UART_ARB_BURST_LIMIT_EN
        burst_d = burst_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    gidx_d  = arb_pick;
                    state_d = S_GRANT;
`ifdef UART_ARB_BURST_LIMIT_EN
                    burst_d = '0;
`endif
                end
            end
            S_GRANT: begin
                // Owner dropped REQ: packet abandoned, release.
                if (!REQ[gidx_q]) begin
                    ptr_d   = wrap_inc(gidx_q);
                    state_d = S_IDLE;
                end else if (TX_IDLE) begin
                    last_d  = REQ_LAST[gidx_q];
                    state_d = S_SEND;
`ifdef UART_ARB_BURST_LIMIT_EN
                    if (burst_q != CNT_W'(MAX_BURST)) begin
                        burst_d = burst_q + CNT_W'(1);
                    end
`endif
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // TX_IDLE has already dropped here; its rise marks byte completion.
                if (TX_IDLE) begin
                    if (last_q || burst_hit_c) begin
                        ptr_d   = wrap_inc(gidx_q);
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GRANT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values, registered alongside the state.
    always_comb begin
        grant_d   = '0;
        ack_d     = '0;
        strobe_d  = 1'b0;
        tx_data_d = TX_DATA;
        busy_d    = (state_d != S_IDLE);
        if (state_d != S_IDLE) begin
            grant_d[gidx_d] = 1'b1;
        end
        // S_SEND is entered only from S_GRANT, so gidx_d equals gidx_q here.
        if (state_d == S_SEND) begin
            strobe_d       = 1'b1;
            ack_d[gidx_d]  = 1'b1;
            tx_data_d      = REQ_DATA[{gidx_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: four requester models, an 8N1 transmitter model
// with a serial-line receiver, and a scoreboard of expected (owner, byte).
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int BIT = 4;   // clock cycles per serial bit

    typedef struct packed {
        logic [1:0] own;
        logic [7:0] data;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [8*N-1:0] REQ_DATA;
    logic [N-1:0]   REQ_LAST;
    logic [N-1:0]   GRANT;
    logic [N-1:0]   ACK;
    logic [7:0]     TX_DATA;
    logic           TX_DATA_READY;
    logic           TX_IDLE;
    logic           BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       sb_q[$];
    logic [7:0] rx_q[$];

    logic [8:0] rq_mem  [N][16];
    logic [3:0] rq_head [N];
    logic [3:0] rq_len  [N];
    logic [3:0] rq_abort[N];

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(2)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
        .GRANT(GRANT), .ACK(ACK), .TX_DATA(TX_DATA), .TX_DATA_READY(TX_DATA_READY),
        .TX_IDLE(TX_IDLE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input int o, input logic [7:0] d);
        sb_q.push_back('{own: 2'(o), data: d});
    endtask

    task automatic load(input int i, input logic [7:0] base, input int n, input int abort);
        for (int k = 0; k < n; k++) begin
            rq_mem[2'(i)][4'(k)] = {(k == n - 1), base + 8'(k)};
        end
        rq_abort[2'(i)] = 4'(abort);
        rq_head[2'(i)]  = 4'd0;
        rq_len[2'(i)]   = 4'(n);
    endtask

    // Requester outputs follow the head of each byte queue.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            REQ[i]            = (rq_head[i] < rq_len[i]);
            REQ_DATA[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
            REQ_LAST[i]       = rq_mem[i][rq_head[i]][8];
        end
    end

    // Pop on ACK; an abort count truncates the packet after that many bytes.
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (ACK[i] && rq_head[i] < rq_len[i]) begin
                rq_head[i] = rq_head[i] + 4'd1;
                if (rq_abort[i] != 4'd0 && rq_head[i] == rq_abort[i]) begin
                    rq_len[i] = rq_head[i];
                end
            end
        end
    end

    // 8N1 transmitter model: samples DATA_READY while idle, IDLE drops next cycle.
    logic       tx_busy;
    logic [9:0] tx_sh;
    int         tx_cyc;
    int         tx_bit;
    logic       tx_line;

    always @(posedge CLK) begin
        if (RST) begin
            tx_busy <= 1'b0;
            tx_sh   <= 10'h3FF;
            tx_cyc  <= 0;
            tx_bit  <= 0;
        end else if (!tx_busy) begin
            if (TX_DATA_READY) begin
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, TX_DATA, 1'b0};
                tx_cyc  <= 0;
                tx_bit  <= 0;
            end
        end else if (tx_cyc == BIT - 1) begin
            tx_cyc <= 0;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 9) tx_busy <= 1'b0;
            else             tx_bit  <= tx_bit + 1;
        end else begin
            tx_cyc <= tx_cyc + 1;
        end
    end

    assign TX_IDLE = !tx_busy;
    assign tx_line = tx_busy ? tx_sh[0] : 1'b1;

    // Serial receiver: sample mid-bit, push the byte on a valid stop bit.
    logic       rx_act;
    int         rx_cnt;
    logic [7:0] rx_byte;

    always @(negedge CLK) begin
        if (RST) begin
            rx_act = 1'b0;
            rx_cnt = 0;
        end else if (!rx_act) begin
            if (!tx_line) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BIT == BIT / 2) begin
                if (rx_cnt / BIT >= 1 && rx_cnt / BIT <= 8) begin
                    rx_byte[3'(rx_cnt / BIT - 1)] = tx_line;
                end else if (rx_cnt / BIT == 9) begin
                    if (tx_line) rx_q.push_back(rx_byte);
                    rx_act = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every transfer pops one expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            chk("grant_onehot", 32'($countones(GRANT) <= 1), 32'h1);
            if (TX_DATA_READY || ACK != '0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: ACK=%b TX_DATA=%h, expected none (t=%0t)",
                             ACK, TX_DATA, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_owner",   32'(ACK),   32'(1) << e.own);
                    chk("grant_owner", 32'(GRANT), 32'(1) << e.own);
                    chk("tx_data",     32'(TX_DATA), 32'(e.data));
                    chk("strobe",      32'(TX_DATA_READY), 32'h1);
                    chk("idle_at_strobe", 32'(TX_IDLE), 32'h1);
                end
            end
        end
    end

    task automatic wait_done(input string name, input int max_cyc);
        int c;
        c = 0;
        while (!(sb_q.size() == 0 && !BUSY && TX_IDLE) && c < max_cyc) begin
            @(negedge CLK);
            c++;
        end
        chk(name, 32'(c < max_cyc), 32'h1);
    endtask

    task automatic wait_ack(input string name, input int i, input int max_cyc);
        int c;
        c = 0;
        while (!ACK[i] && c < max_cyc) begin
            @(negedge CLK);
            c++;
        end
        chk(name, 32'(c < max_cyc), 32'h1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int i = 0; i < N; i++) rq_len[i] = rq_head[i];
        sb_q.delete();
        repeat (2) @(negedge CLK);
        rx_q.delete();
        RST = 1'b0;
    endtask

    initial begin
        int c;
        RST = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq_head[i]  = 4'd0;
            rq_len[i]   = 4'd0;
            rq_abort[i] = 4'd0;
            for (int k = 0; k < 16; k++) rq_mem[i][k] = 9'h000;
        end
        repeat (3) @(negedge CLK);
        chk("rst_grant",  32'(GRANT), 32'h0);
        chk("rst_ack",    32'(ACK), 32'h0);
        chk("rst_strobe", 32'(TX_DATA_READY), 32'h0);
        chk("rst_txdata", 32'(TX_DATA), 32'h0);
        chk("rst_busy",   32'(BUSY), 32'h0);
        RST = 1'b0;

        // Single byte with exact latency.
        @(negedge CLK);
        exp_push(0, 8'hA5);
        load(0, 8'hA5, 1, 0);
        @(negedge CLK);
        chk("t1_grant", 32'(GRANT), 32'h1);
        chk("t1_busy",  32'(BUSY), 32'h1);
        chk("t1_no_strobe_yet", 32'(TX_DATA_READY), 32'h0);
        @(negedge CLK);
        chk("t2_strobe", 32'(TX_DATA_READY), 32'h1);
        chk("t2_ack",    32'(ACK), 32'h1);
        chk("t2_data",   32'(TX_DATA), 32'hA5);
        @(negedge CLK);
        chk("t3_idle_low", 32'(TX_IDLE), 32'h0);
        chk("t3_strobe_low", 32'(TX_DATA_READY), 32'h0);
        c = 0;
        while (!TX_IDLE && c < 100) begin
            @(negedge CLK);
            c++;
        end
        chk("t1_idle_return", 32'(c < 100), 32'h1);
        chk("u_grant_held", 32'(GRANT), 32'h1);
        @(negedge CLK);
        chk("u1_grant_free", 32'(GRANT), 32'h0);
        chk("u1_busy_low",   32'(BUSY), 32'h0);
        chk("serial_count", 32'(rx_q.size()), 32'h1);
        if (rx_q.size() != 0) chk("serial_byte", 32'(rx_q[0]), 32'hA5);

        // Round robin from a fresh pointer.
        do_reset();
        exp_push(0, 8'h11);
        exp_push(1, 8'h22);
        exp_push(2, 8'h33);
        exp_push(3, 8'h44);
        load(0, 8'h11, 1, 0);
        load(1, 8'h22, 1, 0);
        load(2, 8'h33, 1, 0);
        load(3, 8'h44, 1, 0);
        wait_done("rr_done", 400);
        exp_push(0, 8'h55);
        load(0, 8'h55, 1, 0);
        wait_done("rr_again_done", 200);

        // Packet lock: requester 1 arrives after the first byte of requester 2.
        exp_push(2, 8'hC1);
        exp_push(2, 8'hC2);
        exp_push(2, 8'hC3);
        exp_push(1, 8'h9E);
        load(2, 8'hC1, 3, 0);
        wait_ack("lock_first_ack", 2, 100);
        load(1, 8'h9E, 1, 0);
        wait_done("lock_done", 400);

        // Abandon after the first of three bytes.
        exp_push(3, 8'hD0);
        load(3, 8'hD0, 3, 1);
        wait_done("abandon_done", 200);
        repeat (20) @(negedge CLK);
        chk("abandon_grant", 32'(GRANT), 32'h0);
        chk("abandon_busy",  32'(BUSY), 32'h0);

        // Reset while waiting for the transmitter.
        exp_push(0, 8'hE0);
        load(0, 8'hE0, 3, 0);
        wait_ack("rst_first_ack", 0, 100);
        @(negedge CLK);
        chk("rst_wait_busy", 32'(BUSY), 32'h1);
        RST = 1'b1;
        rq_len[0] = rq_head[0];
        @(negedge CLK);
        chk("midrst_grant",  32'(GRANT), 32'h0);
        chk("midrst_ack",    32'(ACK), 32'h0);
        chk("midrst_strobe", 32'(TX_DATA_READY), 32'h0);
        chk("midrst_txdata", 32'(TX_DATA), 32'h0);
        chk("midrst_busy",   32'(BUSY), 32'h0);
        chk("midrst_sb_empty", 32'(sb_q.size()), 32'h0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        // Five-byte packet from 0 with requester 1 pending.
`ifdef UART_ARB_BURST_LIMIT_EN
        exp_push(0, 8'h01);
        exp_push(0, 8'h02);
        exp_push(1, 8'h0A);
        exp_push(0, 8'h03);
        exp_push(0, 8'h04);
        exp_push(0, 8'h05);
`else
        exp_push(0, 8'h01);
        exp_push(0, 8'h02);
        exp_push(0, 8'h03);
        exp_push(0, 8'h04);
        exp_push(0, 8'h05);
        exp_push(1, 8'h0A);
`endif
        load(0, 8'h01, 5, 0);
        load(1, 8'h0A, 1, 0);
        wait_done("burst_done", 1000);
        repeat (5) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one 8N1 UART transmitter (`DATA`/`DATA_READY`/`IDLE` byte interface, 1 MHz bit strobe) between several byte-stream requesters, such as camera status, register readback and debug console. It holds a grant for a whole packet so bytes from different sources never interleave. It issues one byte at a time only when the transmitter reports idle, and acknowledges each byte back to its owner.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `MAX_BURST`, default 16: maximum bytes per grant when the burst limit is compiled in; must be ≥1.
- `CLK` input 1: system clock; also clocks the transmitter.
- `RST` input 1: synchronous, active-high reset.
- `REQ` input N_REQ: per-requester request; held high while a byte is presented.
- `REQ_DATA` input 8*N_REQ: byte of requester i on bits [8i+7:8i].
- `REQ_LAST` input N_REQ: presented byte is the last of its packet.
- `GRANT` output N_REQ: one-hot owner of the transmitter; 0 when free.
- `ACK` output N_REQ: one-cycle pulse; presented byte taken.
- `TX_DATA` output 8: byte to transmitter `DATA`.
- `TX_DATA_READY` output 1: one-cycle send strobe to transmitter `DATA_READY`.
- `TX_IDLE` input 1: transmitter `IDLE`.
- `BUSY` output 1: high whenever state ≠ S_IDLE.

## Operation
- **States:** S_IDLE, S_GRANT, S_SEND, S_WAIT.
- **S_IDLE:** `GRANT`=0. If `REQ`≠0, choose the first set bit searching upward from `ptr`, wrapping modulo N_REQ. Register the one-hot `GRANT`, clear `burst_cnt`, go to S_GRANT.
- **S_GRANT:**
  - If `REQ[g]`=0, release.
  - Else, if `TX_IDLE`=1:
    - register `TX_DATA`=`REQ_DATA[g]`.
    - Assert `TX_DATA_READY`=1 and `ACK[g]`=1 for the next cycle.
    - Latch `last`=`REQ_LAST[g]`.
    - Increment `burst_cnt`.
    - Go to S_SEND.
  - Else, stay in S_GRANT.
- **S_SEND:** lasts one cycle, with the strobe and `ACK` high. Go to S_WAIT; strobe and `ACK` drop.
- **S_WAIT:** stay until `TX_IDLE`=1. Then:
  - if `last`, or the burst limit is reached, release;
  - otherwise go to S_GRANT.
- **Release:**
  - `GRANT`←0.
  - `ptr`←(g+1) mod N_REQ.
  - Go to S_IDLE.
  - The released requester has the lowest priority at the next arbitration.
- **Requester contract:**
  - `REQ_DATA`/`REQ_LAST` stay stable while `REQ` is high and until `ACK`.
  - After `ACK`, the next byte may be presented from the following cycle.
  - Dropping `REQ` while granted abandons the packet. A byte already in flight completes; release happens at the next S_GRANT evaluation.
- **Ignored inputs:** `REQ` of non-granted requesters has no effect while the transmitter is granted. `REQ_DATA` of non-granted requesters never reaches `TX_DATA`.
- **`burst_cnt` width:** $clog2(MAX_BURST+1); it never wraps.

## Timing
- **Reset values:** `GRANT`=0, `ACK`=0, `TX_DATA_READY`=0, `TX_DATA`=8'h00, `BUSY`=0, `ptr`=0, state S_IDLE. Reset mid-packet abandons the packet with no further `ACK`. The transmitter shares `RST`.
- **First-byte latency:** `REQ` seen at cycle t in S_IDLE:
  - `GRANT` at t+1;
  - `TX_DATA_READY`/`ACK` at t+2, if `TX_IDLE`=1 at t+1;
  - `TX_IDLE` falls at t+3.
- **S_WAIT guard:** the transmitter samples in the strobe cycle and drops `IDLE` the next cycle. S_WAIT therefore never sees stale `TX_IDLE` high from before the send.
- **Consecutive bytes in a packet:** `TX_IDLE` rise at cycle u gives S_GRANT at u+1 and strobe at u+2.
- **Release to next grant:** release at S_WAIT exit, cycle u, gives `GRANT`=0 at u+1 and the next `GRANT` at u+2.
- **Strobe rules:** `TX_DATA_READY` is never high while `TX_IDLE` is low. The strobe is never longer than one cycle.

## Configuration
- **With `UART_ARB_BURST_LIMIT_EN` defined:** the grant is released after `MAX_BURST` bytes even without `REQ_LAST`. The requester must re-arbitrate to continue, and `ptr` advances past it.
- **Without `UART_ARB_BURST_LIMIT_EN`:** the grant is held until a byte with `REQ_LAST`=1 completes, or `REQ` drops. `MAX_BURST` is ignored.

## Test plan
- **Single byte:** reset, then `REQ[0]`=1 with 8'hA5 and `LAST`=1, using a transmitter model → `GRANT`=4'b0001 at t+1. Then strobe and `ACK[0]` one cycle at t+2, `TX_DATA`=8'hA5. Then `GRANT`=0 one cycle after `TX_IDLE` returns. Serial line shows start, 8'hA5 LSB first, stop.
- **Round-robin:** `REQ`=4'b1111, each a 1-byte packet → grant order 0,1,2,3, then 0 again if re-requested. No two `GRANT` bits are ever set.
- **Packet lock:** `REQ[2]` sends a 3-byte packet; `REQ[1]` rises after the first `ACK` → all 3 bytes from requester 2 go out before `GRANT[1]`.
- **Abandon and reset:** `REQ[3]` drops after the first of 3 bytes → that byte completes, then release with no more `ACK`. Separately, `RST` during S_WAIT → all outputs at reset values the next cycle.
- **Burst limit:** with `UART_ARB_BURST_LIMIT_EN`, `MAX_BURST`=2, `REQ[0]` 5-byte packet and `REQ[1]` pending → bytes 0,0,1,0,0,… Without the macro → 5 bytes from requester 0 first.
